// File: rtl/apb_req_arbiter_pkg.sv
// Shared widths, FSM state type and slave-select helper for the APB arbiter.
package apb_arb_pkg;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;
   localparam int STRB_W = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   // Upper address bit picks one of two slaves.
   function automatic logic [1:0] slave_sel(input logic msb);
      return msb ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between the arbiter (master) and its slaves.
interface apb_req_arbiter_if;
   import apb_arb_pkg::*;

   logic [1:0]        psel;
   logic              penable;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pwrite;
   logic [STRB_W-1:0] pstrb;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, paddr,
      output pwdata, pwrite, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, paddr,
      input  pwdata, pwrite, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_rr_arb.sv
// Two-way round-robin grant: with both valid, favour the one not granted last.
module apb_rr_arb (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       en,
   input  logic       last_gnt,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (1'b1)
            (valid0 && valid1):  gnt = last_gnt ? 2'b01 : 2'b10;
            (valid0 && !valid1): gnt = 2'b01;
            (!valid0 && valid1): gnt = 2'b10;
            default:             gnt = 2'b00;
         endcase
      end
   end
endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master arbiter; define APB_ARB_TIMEOUT_EN for ACCESS timeout.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req0_write,
   input  logic [STRB_W-1:0] req0_strb,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic              req1_write,
   input  logic [STRB_W-1:0] req1_strb,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   apb_req_arbiter_if.master apb
);
   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t state, nxt;
   logic [1:0] gnt;
   logic gnt_en, fin, tout;
   logic owner, rr_last, run_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic wr_q;
   logic [STRB_W-1:0] strb_q;
   logic [1:0] done_q, err_q;
   logic [1:0][DATA_W-1:0] rdata_q;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic t_hit;
   assign t_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

   apb_rr_arb u_rr (
      .valid0   (req0_valid),
      .valid1   (req1_valid),
      .en       (gnt_en),
      .last_gnt (rr_last),
      .gnt      (gnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt    = state;
      gnt_en = 1'b0;
      fin    = 1'b0;
      tout   = 1'b0;
      case (state)
         S_IDLE: begin
            gnt_en = run_q;
            if (gnt != 2'b00) nxt = S_SETUP;
         end
         S_SETUP: nxt = S_ACCESS;
         S_ACCESS: begin
            if (apb.pready) begin
               fin = 1'b1;
               nxt = S_IDLE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (t_hit) begin
               fin  = 1'b1;
               tout = 1'b1;
               nxt  = S_IDLE;
            end
`endif
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q   <= 1'b0;
         rr_last <= 1'b1;
         owner   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         strb_q  <= '0;
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         run_q  <= 1'b1;
         done_q <= '0;
         if (gnt[0]) begin
            owner   <= 1'b0;
            rr_last <= 1'b0;
            addr_q  <= req0_addr;
            wdata_q <= req0_wdata;
            wr_q    <= req0_write;
            strb_q  <= req0_strb;
         end else if (gnt[1]) begin
            owner   <= 1'b1;
            rr_last <= 1'b1;
            addr_q  <= req1_addr;
            wdata_q <= req1_wdata;
            wr_q    <= req1_write;
            strb_q  <= req1_strb;
         end
         if (fin) begin
            done_q[owner] <= 1'b1;
            err_q[owner]  <= tout | apb.pslverr;
            if (tout)
               rdata_q[owner] <= '0;
            else if (!wr_q)
               rdata_q[owner] <= apb.prdata;
         end
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tcnt <= '0;
      else if (state == S_ACCESS && !apb.pready && !tout)
         tcnt <= tcnt + 1'b1;
      else
         tcnt <= '0;
   end
`endif

   assign apb.psel    = (state != S_IDLE) ? slave_sel(addr_q[ADDR_W-1]) : 2'b00;
   assign apb.penable = (state == S_ACCESS);
   assign apb.paddr   = addr_q;
   assign apb.pwdata  = wdata_q;
   assign apb.pwrite  = wr_q;
   assign apb.pstrb   = strb_q;

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign req0_done  = done_q[0];
   assign req1_done  = done_q[1];
   assign req0_err   = err_q[0];
   assign req1_err   = err_q[1];
   assign req0_rdata = rdata_q[0];
   assign req1_rdata = rdata_q[1];
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter; timeout checks follow APB_ARB_TIMEOUT_EN.
module tb_apb_req_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic r0_v, r0_w, r0_rdy, r0_dn, r0_err;
   logic r1_v, r1_w, r1_rdy, r1_dn, r1_err;
   logic [19:0] r0_a, r1_a;
   logic [15:0] r0_wd, r1_wd, r0_rd, r1_rd;
   logic [1:0] r0_s, r1_s;
   int n_cmp = 0;
   int n_bad = 0;

   apb_req_arbiter_if apb ();

   apb_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0_valid (r0_v),
      .req0_addr  (r0_a),
      .req0_wdata (r0_wd),
      .req0_write (r0_w),
      .req0_strb  (r0_s),
      .req0_ready (r0_rdy),
      .req0_done  (r0_dn),
      .req0_rdata (r0_rd),
      .req0_err   (r0_err),
      .req1_valid (r1_v),
      .req1_addr  (r1_a),
      .req1_wdata (r1_wd),
      .req1_write (r1_w),
      .req1_strb  (r1_s),
      .req1_ready (r1_rdy),
      .req1_done  (r1_dn),
      .req1_rdata (r1_rd),
      .req1_err   (r1_err),
      .apb        (apb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      r0_v = 0; r0_w = 0; r0_a = '0; r0_wd = '0; r0_s = '0;
      r1_v = 0; r1_w = 0; r1_a = '0; r1_wd = '0; r1_s = '0;
      apb.prdata = '0; apb.pready = 0; apb.pslverr = 0;

      // reset state
      cyc();
      cyc();
      chk("rst_psel", apb.psel, 0);
      chk("rst_penable", apb.penable, 0);
      chk("rst_paddr", apb.paddr, 0);
      chk("rst_pwdata", apb.pwdata, 0);
      chk("rst_rdy", {r0_rdy, r1_rdy}, 0);
      chk("rst_done", {r0_dn, r1_dn}, 0);
      chk("rst_rdata0", r0_rd, 0);
      chk("rst_err", {r0_err, r1_err}, 0);
      reset_n = 1'b1;
      cyc();

      // req0 write, zero wait states
      r0_v = 1; r0_w = 1; r0_a = 20'h00010;
      r0_wd = 16'h1234; r0_s = 2'b11;
      apb.pready = 1;
      #1;
      chk("wr_ready0", r0_rdy, 1);
      chk("wr_ready1", r1_rdy, 0);
      cyc();
      r0_v = 0;
      #1;
      chk("wr_setup_psel", apb.psel, 2'b01);
      chk("wr_setup_pen", apb.penable, 0);
      chk("wr_paddr", apb.paddr, 20'h00010);
      chk("wr_pwdata", apb.pwdata, 16'h1234);
      chk("wr_pwrite", apb.pwrite, 1);
      chk("wr_pstrb", apb.pstrb, 2'b11);
      cyc();
      chk("wr_acc_pen", apb.penable, 1);
      chk("wr_acc_psel", apb.psel, 2'b01);
      cyc();
      chk("wr_done0", r0_dn, 1);
      chk("wr_err0", r0_err, 0);
      chk("wr_idle_psel", apb.psel, 0);
      chk("wr_idle_pen", apb.penable, 0);
      chk("wr_idle_hold", apb.paddr, 20'h00010);
      apb.pready = 0;
      cyc();
      chk("wr_done_pulse", r0_dn, 0);

      // req1 read with two wait states
      r1_v = 1; r1_w = 0; r1_a = 20'h80004;
      #1;
      chk("rd_ready1", r1_rdy, 1);
      cyc();
      r1_v = 0;
      #1;
      chk("rd_setup_psel", apb.psel, 2'b10);
      chk("rd_setup_pen", apb.penable, 0);
      cyc();
      chk("rd_wait1_pen", apb.penable, 1);
      cyc();
      chk("rd_wait2_pen", apb.penable, 1);
      chk("rd_wait2_done", r1_dn, 0);
      cyc();
      apb.pready = 1; apb.prdata = 16'hABCD;
      #1;
      chk("rd_acc3_pen", apb.penable, 1);
      cyc();
      chk("rd_done1", r1_dn, 1);
      chk("rd_rdata1", r1_rd, 16'hABCD);
      chk("rd_err1", r1_err, 0);
      chk("rd_idle_pen", apb.penable, 0);
      cyc();
      chk("rd_done_once", r1_dn, 0);

      // both valid: grants alternate 0,1,0,1
      r0_v = 1; r0_w = 1; r0_a = 20'h00020;
      r0_wd = 16'h1111; r0_s = 2'b01;
      r1_v = 1; r1_w = 1; r1_a = 20'h80020;
      r1_wd = 16'h2222; r1_s = 2'b10;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready0", r0_rdy, (k % 2 == 0));
         chk("rr_ready1", r1_rdy, (k % 2 == 1));
         if (k > 0) begin
            chk("rr_b2b_done0", r0_dn, (k % 2 == 1));
            chk("rr_b2b_done1", r1_dn, (k % 2 == 0));
         end
         cyc();
         chk("rr_psel", apb.psel,
             (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_pwdata", apb.pwdata,
             (k % 2 == 0) ? 16'h1111 : 16'h2222);
         cyc();
         if (k == 3) begin
            r0_v = 0; r1_v = 0;
         end
         cyc();
      end
      chk("rr_last_done1", r1_dn, 1);
      chk("rr_idle_rdy", {r0_rdy, r1_rdy}, 0);

      // read with slave error
      r0_v = 1; r0_w = 0; r0_a = 20'h00040;
      apb.pslverr = 1; apb.prdata = 16'h5A5A;
      #1;
      chk("se_ready0", r0_rdy, 1);
      cyc();
      r0_v = 0;
      cyc();
      cyc();
      chk("se_done0", r0_dn, 1);
      chk("se_err0", r0_err, 1);
      chk("se_rdata0", r0_rd, 16'h5A5A);

      // write must leave rdata alone
      r0_v = 1; r0_w = 1; r0_a = 20'h00050;
      apb.pslverr = 0; apb.prdata = 16'hFFFF;
      #1;
      chk("wk_ready0", r0_rdy, 1);
      cyc();
      r0_v = 0;
      cyc();
      cyc();
      chk("wk_done0", r0_dn, 1);
      chk("wk_rdata0", r0_rd, 16'h5A5A);
      chk("wk_err0", r0_err, 0);

      // slave never ready
      r0_v = 1; r0_w = 0; r0_a = 20'h00060;
      apb.pready = 0;
      #1;
      cyc();
      r0_v = 0;
      cyc();
`ifdef APB_ARB_TIMEOUT_EN
      repeat (15) cyc();
      chk("to_acc16_pen", apb.penable, 1);
      chk("to_acc16_done", r0_dn, 0);
      cyc();
      chk("to_done0", r0_dn, 1);
      chk("to_err0", r0_err, 1);
      chk("to_rdata0", r0_rd, 16'h0000);
      r1_v = 1; r1_w = 0; r1_a = 20'h80060;
      #1;
      cyc();
      r1_v = 0;
      cyc();
`else
      repeat (19) cyc();
      chk("nt_stall_pen", apb.penable, 1);
      chk("nt_stall_psel", apb.psel, 2'b01);
      chk("nt_stall_done", r0_dn, 0);
`endif

      // reset during ACCESS
      reset_n = 1'b0;
      #1;
      chk("mr_psel", apb.psel, 0);
      chk("mr_pen", apb.penable, 0);
      chk("mr_paddr", apb.paddr, 0);
      chk("mr_pwrite", apb.pwrite, 0);
      chk("mr_pstrb", apb.pstrb, 0);
      chk("mr_rdata0", r0_rd, 0);
      chk("mr_err", {r0_err, r1_err}, 0);
      chk("mr_done", {r0_dn, r1_dn}, 0);
      r0_v = 1; r1_v = 1; r0_w = 1; r0_a = 20'h00070;
      apb.pready = 1;
      #1;
      chk("mr_rdy_in_rst", {r0_rdy, r1_rdy}, 0);
      cyc();
      cyc();
      chk("mr_no_done", {r0_dn, r1_dn}, 0);
      reset_n = 1'b1;
      cyc();
      chk("mr_grant0", r0_rdy, 1);
      chk("mr_grant1", r1_rdy, 0);
      cyc();
      r0_v = 0; r1_v = 0;
      #1;
      chk("mr_psel_after", apb.psel, 2'b01);
      cyc();
      cyc();
      chk("mr_done_after", r0_dn, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
